// File: rtl/bocks_pkg.sv
// Shared types for the bocks framebuffer loader.
// No logic; enum and struct definitions only.
// The word-address field is sized for the largest usable FB_AW.
package bocks_pkg;

    // ioctl_addr is 27 bits, so a word address never needs more than 26.
    localparam int FB_AW_MAX = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    // Upper address bits above the instance's FB_AW are always zero.
    typedef struct packed {
        logic [FB_AW_MAX-1:0] addr;
        logic [15:0]          data;
        logic [1:0]           be;
    } fb_wr_t;

endpackage

// File: rtl/bocks_sync_fifo.sv
// Synchronous FIFO with a registered head entry (head_vld/head_dat).
// Latency: a push becomes visible at the head two edges later at the earliest.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module bocks_sync_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  T                         push_dat,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_vld,
    output T                         head_dat
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr_nxt;
    logic [AW:0]    avail;
    logic           do_pop;
    logic           do_push;

    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign do_pop     = pop && head_vld;
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_nxt = rd_ptr + AW'(do_pop);
    // Entries already stored that can be presented next cycle.
    assign avail      = count - (AW+1)'(do_pop);

    // Storage write; the slot under rd_ptr is only overwritten when it is being popped.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers, occupancy and the registered head copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            head_vld <= 1'b0;
            head_dat <= '0;
        end else begin
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr + AW'(do_push);
            count    <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            head_vld <= (avail != '0);
            head_dat <= mem[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/bocks_ioctl_loader.sv
// Packs the hps_io ioctl byte stream into byte-enabled 16-bit framebuffer writes.
// Latency: byte sampled on edge N is staged at N, in the FIFO at N+1, on mem_req at N+2.
// Backpressure: ioctl_wait at FIFO occupancy >= DEPTH-2 and throughout FLUSH/DONE.
module bocks_ioctl_loader
    import bocks_pkg::*;
#(
    parameter int         FB_AW      = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] INDEX      = 8'd1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ioctl_download,
    input  logic [7:0]       ioctl_index,
    input  logic             ioctl_wr,
    input  logic [26:0]      ioctl_addr,
    input  logic [7:0]       ioctl_dout,
    output logic             ioctl_wait,
    output logic             mem_req,
    output logic [FB_AW-1:0] mem_addr,
    output logic [15:0]      mem_data,
    output logic [1:0]       mem_be,
    input  logic             mem_ack,
    output logic             busy,
    output logic             done,
    output logic [26:0]      byte_count,
    output logic [7:0]       checksum,
    output logic             overflow,
    output logic             range_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    loader_state_t          state;
    fb_wr_t                 pend, pend_nxt;
    fb_wr_t                 stage, stage_nxt;
    fb_wr_t                 head;
    logic                   pend_vld, pend_vld_nxt;
    logic                   stage_vld, stage_vld_nxt;
    logic                   flow_wait;
    logic                   fifo_pop, fifo_full, fifo_empty, head_vld;
    logic [CW-1:0]          fifo_count;
    logic [CW:0]            room_used;
    logic                   accept, in_range, take, flush_ok;
    logic [FB_AW_MAX-1:0]   word;
    logic                   head_addr_unused;

    assign in_range  = ((ioctl_addr >> (FB_AW + 1)) == 27'd0);
    assign accept    = (state == ST_LOAD) && ioctl_wr;
    assign take      = accept && in_range;
    assign word      = FB_AW_MAX'(ioctl_addr[FB_AW:1]);
    assign fifo_pop  = head_vld && mem_ack;
    // Staged entry counts against capacity so the flush never overruns the FIFO.
    assign room_used = {1'b0, fifo_count} + (CW+1)'(stage_vld);
    assign flush_ok  = (room_used < (CW+1)'(FIFO_DEPTH));

    // Packing decision: at most one entry leaves for the staging register per cycle.
    always_comb begin
        pend_nxt      = pend;
        pend_vld_nxt  = pend_vld;
        stage_nxt     = pend;
        stage_vld_nxt = 1'b0;
        if (take) begin
            if (!ioctl_addr[0]) begin
                stage_vld_nxt = pend_vld;
                pend_nxt      = '{addr: word, data: {8'h00, ioctl_dout}, be: 2'b01};
                pend_vld_nxt  = 1'b1;
            end else if (pend_vld && (pend.addr == word)) begin
                stage_vld_nxt = 1'b1;
                stage_nxt     = '{addr: word, data: {ioctl_dout, pend.data[7:0]}, be: 2'b11};
                pend_vld_nxt  = 1'b0;
            end else begin
                stage_vld_nxt = 1'b1;
                stage_nxt     = '{addr: word, data: {ioctl_dout, 8'h00}, be: 2'b10};
            end
        end else if ((state == ST_FLUSH) && pend_vld && flush_ok) begin
            stage_vld_nxt = 1'b1;
            pend_vld_nxt  = 1'b0;
        end
    end

    // Control FSM, packing registers, accounting and registered status outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            pend       <= '0;
            pend_vld   <= 1'b0;
            stage      <= '0;
            stage_vld  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            flow_wait  <= 1'b0;
            byte_count <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            pend      <= pend_nxt;
            pend_vld  <= pend_vld_nxt;
            stage     <= stage_nxt;
            stage_vld <= stage_vld_nxt;
            done      <= 1'b0;
            if (stage_vld && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (ioctl_download && (ioctl_index == INDEX)) begin
                        state      <= ST_LOAD;
                        busy       <= 1'b1;
                        byte_count <= '0;
                        checksum   <= '0;
                        overflow   <= 1'b0;
                        range_err  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (in_range) begin
                            byte_count <= byte_count + 27'd1;
                            checksum   <= checksum + ioctl_dout;
                        end else begin
                            range_err  <= 1'b1;
                        end
                    end
                    if (!ioctl_download) begin
                        state     <= ST_FLUSH;
                        flow_wait <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (!pend_vld && !stage_vld && fifo_empty) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    flow_wait <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bocks_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fb_wr_t)
    ) u_fifo (
        .clk      (clk_sys),
        .rst_n    (reset_n),
        .push     (stage_vld),
        .push_dat (stage),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head_vld (head_vld),
        .head_dat (head)
    );

    assign mem_req          = head_vld;
    assign mem_addr         = head.addr[FB_AW-1:0];
    assign mem_data         = head.data;
    assign mem_be           = head.be;
    assign ioctl_wait       = flow_wait || (fifo_count >= CW'(FIFO_DEPTH - 2));
    assign head_addr_unused = ^head.addr;

endmodule

// File: tb/tb_bocks_ioctl_loader.sv
// Self-checking bench for bocks_ioctl_loader: memory writes go through a scoreboard queue,
// each scenario task checks its own status outputs inline.
module tb_bocks_ioctl_loader;
    localparam int FB_AW = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic [1:0]  mem_be;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic [26:0] byte_count;
    logic [7:0]  checksum;
    logic        overflow;
    logic        range_err;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [15:0] mon_mask;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;

    bocks_ioctl_loader #(.FB_AW(FB_AW), .FIFO_DEPTH(8), .INDEX(8'd1)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be),
        .mem_ack(mem_ack),
        .busy(busy), .done(done), .byte_count(byte_count), .checksum(checksum),
        .overflow(overflow), .range_err(range_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Scoreboard: a write completes on the coming edge whenever req and ack are both high.
    always @(negedge clk_sys) begin
        if (reset_n && mem_req && mem_ack) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL mem_write unexpected: addr=%h data=%h be=%b", mem_addr, mem_data, mem_be);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_mask = {{8{mon_e.be[1]}}, {8{mon_e.be[0]}}};
                if (mem_addr !== mon_e.addr || mem_be !== mon_e.be ||
                    (mem_data & mon_mask) !== (mon_e.data & mon_mask)) begin
                    $display("FAIL mem_write: got addr=%h data=%h be=%b, want addr=%h data=%h be=%b",
                             mem_addr, mem_data, mem_be, mon_e.addr, mon_e.data, mon_e.be);
                end else begin
                    n_pass++;
                end
            end
        end
        if (reset_n && done) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic exp_push(input int a, input logic [15:0] d, input logic [1:0] be);
        wr_t e;
        e.addr = 16'(a);
        e.data = d;
        e.be   = be;
        exp_q.push_back(e);
    endtask

    // Honours ioctl_wait like hps_io, then strobes one byte.
    task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
        int guard;
        guard = 0;
        while (ioctl_wait && guard < 2000) begin
            tick();
            guard++;
        end
        if (guard >= 2000) begin
            n_checks++;
            $display("FAIL send_byte: ioctl_wait stuck high, got 1 want 0");
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic begin_load(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic finish_load(output bit got);
        ioctl_download = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({mem_req, busy, done, ioctl_wait, overflow, range_err} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {mem_req, busy, done, ioctl_wait, overflow, range_err});
        else n_pass++;
        n_checks++;
        if (byte_count !== 27'd0) $display("FAIL reset_count: got %0d want 0", byte_count);
        else n_pass++;
        n_checks++;
        if (checksum !== 8'd0) $display("FAIL reset_checksum: got %h want 00", checksum);
        else n_pass++;
        reset_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_sequential();
        bit got;
        int d0;
        logic [7:0] sum, d, prev;
        sum = 8'd0;
        prev = 8'd0;
        d0 = done_cnt;
        mem_ack = 1'b1;
        begin_load(8'd1);
        for (int i = 0; i < 6; i++) begin
            d = 8'h10 + 8'(i);
            sum = sum + d;
            if (i % 2 == 1) exp_push(i / 2, {d, prev}, 2'b11);
            prev = d;
            send_byte(27'(i), d);
        end
        finish_load(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL seq_done: got %b want 1", got); else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL seq_drained: got %0d pending want 0", exp_q.size()); else n_pass++;
        n_checks++;
        if (byte_count !== 27'd6) $display("FAIL seq_count: got %0d want 6", byte_count); else n_pass++;
        n_checks++;
        if (checksum !== sum) $display("FAIL seq_checksum: got %h want %h", checksum, sum); else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL seq_done_pulses: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL seq_idle: busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_odd_length();
        bit got;
        mem_ack = 1'b1;
        begin_load(8'd1);
        exp_push(0, 16'hBBAA, 2'b11);
        send_byte(27'd0, 8'hAA);
        send_byte(27'd1, 8'hBB);
        send_byte(27'd2, 8'hCC);
        exp_push(1, 16'h00CC, 2'b01);
        ioctl_download = 1'b0;
        tick();
        n_checks++;
        if (ioctl_wait !== 1'b1) $display("FAIL odd_flush_wait: got %b want 1", ioctl_wait); else n_pass++;
        finish_load(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL odd_done: got %b want 1", got); else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL odd_drained: got %0d pending want 0", exp_q.size()); else n_pass++;
        n_checks++;
        if (byte_count !== 27'd3) $display("FAIL odd_count: got %0d want 3", byte_count); else n_pass++;
        n_checks++;
        if (checksum !== 8'h31) $display("FAIL odd_checksum: got %h want 31", checksum); else n_pass++;
        repeat (2) tick();
    endtask

    task automatic test_odd_start();
        bit got;
        mem_ack = 1'b1;
        begin_load(8'd1);
        exp_push(3, 16'h5A00, 2'b10);
        send_byte(27'd7, 8'h5A);
        send_byte(27'd8, 8'h11);
        exp_push(4, 16'h0011, 2'b01);
        send_byte(27'd10, 8'h22);
        exp_push(5, 16'h0022, 2'b01);
        finish_load(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL ostart_done: got %b want 1", got); else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL ostart_drained: got %0d pending want 0", exp_q.size()); else n_pass++;
        n_checks++;
        if (byte_count !== 27'd3) $display("FAIL ostart_count: got %0d want 3", byte_count); else n_pass++;
        n_checks++;
        if (checksum !== 8'h8D) $display("FAIL ostart_checksum: got %h want 8d", checksum); else n_pass++;
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        bit got;
        logic [7:0] sum, prev;
        sum = 8'd0;
        prev = 8'd0;
        mem_ack = 1'b0;
        begin_load(8'd1);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            d = 8'(i * 7 + 3);
            sum = sum + d;
            if (i % 2 == 1) exp_push(i / 2, {d, prev}, 2'b11);
            prev = d;
            send_byte(27'(i), d);
        end
        repeat (3) tick();
        n_checks++;
        if (ioctl_wait !== 1'b0) $display("FAIL bp_wait_at5: got %b want 0", ioctl_wait); else n_pass++;
        n_checks++;
        if (mem_req !== 1'b1) $display("FAIL bp_req_held: got %b want 1", mem_req); else n_pass++;
        for (int i = 10; i < 12; i++) begin
            logic [7:0] d;
            d = 8'(i * 7 + 3);
            sum = sum + d;
            if (i % 2 == 1) exp_push(i / 2, {d, prev}, 2'b11);
            prev = d;
            send_byte(27'(i), d);
        end
        repeat (3) tick();
        n_checks++;
        if (ioctl_wait !== 1'b1) $display("FAIL bp_wait_at6: got %b want 1", ioctl_wait); else n_pass++;
        fork
            begin
                repeat (4) tick();
                mem_ack = 1'b1;
            end
            begin
                for (int i = 12; i < 20; i++) begin
                    logic [7:0] d;
                    d = 8'(i * 7 + 3);
                    sum = sum + d;
                    if (i % 2 == 1) exp_push(i / 2, {d, prev}, 2'b11);
                    prev = d;
                    send_byte(27'(i), d);
                end
            end
        join
        finish_load(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL bp_done: got %b want 1", got); else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL bp_drained: got %0d pending want 0", exp_q.size()); else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL bp_overflow: got %b want 0", overflow); else n_pass++;
        n_checks++;
        if (byte_count !== 27'd20) $display("FAIL bp_count: got %0d want 20", byte_count); else n_pass++;
        n_checks++;
        if (checksum !== sum) $display("FAIL bp_checksum: got %h want %h", checksum, sum); else n_pass++;
        repeat (2) tick();
    endtask

    task automatic test_range_index();
        bit got;
        mem_ack = 1'b1;
        begin_load(8'd1);
        send_byte(27'h20000, 8'h77);
        exp_push(0, 16'h4200, 2'b10);
        send_byte(27'd1, 8'h42);
        finish_load(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL range_done: got %b want 1", got); else n_pass++;
        n_checks++;
        if (range_err !== 1'b1) $display("FAIL range_err: got %b want 1", range_err); else n_pass++;
        n_checks++;
        if (byte_count !== 27'd1) $display("FAIL range_count: got %0d want 1", byte_count); else n_pass++;
        n_checks++;
        if (checksum !== 8'h42) $display("FAIL range_checksum: got %h want 42", checksum); else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL range_drained: got %0d pending want 0", exp_q.size()); else n_pass++;
        repeat (2) tick();
        begin_load(8'd2);
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL index_busy: got %b want 0", busy); else n_pass++;
        send_byte(27'd2, 8'h99);
        ioctl_download = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (byte_count !== 27'd1 || checksum !== 8'h42 || range_err !== 1'b1)
            $display("FAIL index_counters: got count=%0d sum=%h rerr=%b want 1/42/1", byte_count, checksum, range_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        bit got;
        mem_ack = 1'b0;
        begin_load(8'd1);
        for (int i = 0; i < 6; i++) send_byte(27'(i), 8'hC0 + 8'(i));
        repeat (3) tick();
        n_checks++;
        if (mem_req !== 1'b1) $display("FAIL rst_req_before: got %b want 1", mem_req); else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL rst_req_async: got %b want 0", mem_req); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst_busy_async: got %b want 0", busy); else n_pass++;
        ioctl_download = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        mem_ack = 1'b1;
        begin_load(8'd1);
        exp_push(0, 16'hD1D0, 2'b11);
        exp_push(1, 16'hD3D2, 2'b11);
        for (int i = 0; i < 4; i++) send_byte(27'(i), 8'hD0 + 8'(i));
        finish_load(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL rst_fresh_done: got %b want 1", got); else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL rst_fresh_drained: got %0d pending want 0", exp_q.size()); else n_pass++;
        n_checks++;
        if (byte_count !== 27'd4) $display("FAIL rst_fresh_count: got %0d want 4", byte_count); else n_pass++;
        n_checks++;
        if (checksum !== 8'h46) $display("FAIL rst_fresh_checksum: got %h want 46", checksum); else n_pass++;
        repeat (2) tick();
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        mem_ack        = 1'b0;
        test_reset();
        test_sequential();
        test_odd_length();
        test_odd_start();
        test_backpressure();
        test_range_index();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
